// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared sizes, FSM encoding and length clamp for checker_mem_loader
package checker_pkg;

  localparam int DEPTH  = 2048;
  localparam int IDX_W  = 11;
  localparam int LEN_W  = 12;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DUMP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Requests longer than the memory are clipped to exactly one full pass.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req_len,
                                                 input int               depth);
    logic [LEN_W-1:0] cap;
    cap = LEN_W'(depth);
    return (req_len > cap) ? cap : req_len;
  endfunction

endpackage

// File: rtl/checker_byte_fifo2.sv
// rtl/checker_byte_fifo2.sv - two-entry byte FIFO with simultaneous push/pop
module checker_byte_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] push_data,
  output logic [7:0] data,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  logic [7:0] mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/checker_mem_loader.sv
// rtl/checker_mem_loader.sv - streams bytes into or out of a word-addressed memory, one byte per word
module checker_mem_loader
  import checker_pkg::*;
#(
  parameter int DEPTH = checker_pkg::DEPTH,
  parameter int IDX_W = checker_pkg::IDX_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             mode,
  input  logic [IDX_W-1:0] base,
  input  logic [11:0]      len,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      mem_addr,
  output logic [3:0]       mem_we,
  output logic [31:0]      mem_di,
  input  logic [31:0]      mem_do
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             inflight_q, inflight_d;

  logic [LEN_W-1:0] start_len;
  logic             last_cnt;
  logic             load_rdy;
  logic             beat;
  logic             issue;
  logic [2:0]       occ;

  logic             fifo_pop;
  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_count;
  logic             unused_mem_hi;

  assign unused_mem_hi = ^{mem_do[31:8], fifo_full};

  assign start_len = clamp_len(len, DEPTH);
  assign last_cnt  = (cnt_q == len_q - LEN_W'(1));
  assign load_rdy  = (state_q == ST_LOAD) && (cnt_q < len_q);
  assign beat      = load_rdy & in_valid;
  assign fifo_pop  = ~fifo_empty & out_ready;
  assign occ       = 3'(fifo_count) + 3'(inflight_q);
  // Counting the same-cycle pop as free space keeps a steady 1 byte/cycle with out_ready high.
  assign issue     = (state_q == ST_DUMP) && (cnt_q < len_q) &&
                     ((occ - 3'(fifo_pop)) < 3'd2);

  checker_byte_fifo2 u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (inflight_q),
    .pop       (fifo_pop),
    .push_data (mem_do[7:0]),
    .data      (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    inflight_d = issue;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d = base;
          cnt_d = '0;
          len_d = start_len;
          if (start_len == '0) begin
            state_d = ST_DONE;
          end else if (mode) begin
            state_d = ST_DUMP;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (beat) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = cnt_q + LEN_W'(1);
          if (last_cnt) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DUMP: begin
        if (issue) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = cnt_q + LEN_W'(1);
          if (last_cnt) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !inflight_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    in_ready  = load_rdy;
    mem_we    = beat ? 4'b0001 : 4'b0000;
    mem_di    = beat ? {24'b0, in_data} : 32'b0;
    mem_addr  = (beat || issue) ? 16'({idx_q, 3'b000}) : 16'b0;
    out_valid = ~fifo_empty;
    out_data  = fifo_data;
  end

endmodule

// File: doc/checker_mem_loader.md
CHECKER_MEM_LOADER -- requirements
Module: checker_mem_loader

Interface
REQ-001 The block SHALL have parameters:
- DEPTH, 2048, memory depth in bytes.
- IDX_W, 11, byte index width, log2(DEPTH).

REQ-002 The block SHALL have ports (name, direction, width, meaning):
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  begin a transfer; sampled only in IDLE.
- mode  in  1  0 = load (stream into memory), 1 = dump (memory onto stream).
- base  in  IDX_W  first byte index.
- len  in  12  byte count.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle completion pulse.
- in_data  in  8  load stream byte.
- in_valid  in  1  load stream valid.
- in_ready  out  1  load stream ready.
- out_data  out  8  dump stream byte.
- out_valid  out  1  dump stream valid.
- out_ready  in  1  dump stream ready.
- mem_addr  out  16  memory port address.
- mem_we  out  4  memory port byte write enables.
- mem_di  out  32  memory port write data.
- mem_do  in  32  memory port read data, registered, 1-cycle latency.

Function
REQ-003 Byte index k SHALL map to mem_addr = {1'b0, 1'b0, k[IDX_W-1:0], 3'b000}, data on lane 0 (mem_di[7:0], mem_do[7:0]).
REQ-004 The FSM SHALL have states IDLE, LOAD, DUMP, DRAIN, DONE.
REQ-005 In IDLE, start=1 SHALL latch base, mode and effective length L = min(len, 2048); the FSM enters LOAD (mode 0) or DUMP (mode 1).
REQ-006 A start with L = 0 SHALL go directly to DONE with no memory access.
REQ-007 start SHALL be ignored outside IDLE.
REQ-008 Index SHALL increment by 1 per beat and wrap modulo DEPTH (2047 -> 0).
REQ-009 In LOAD:
- in_ready = 1 while the beat count < L.
- Each beat (in_valid & in_ready) SHALL drive, in the same cycle, mem_we = 4'b0001, mem_di = {24'b0, in_data} and mem_addr for the current index.
- After beat L the FSM SHALL enter DONE.
REQ-010 mem_we SHALL be 4'b0000 in every cycle without a LOAD beat; in_ready SHALL be 0 outside LOAD.
REQ-011 In DUMP:
- A read is issued (mem_addr = index, mem_we = 0) when issued-count < L and the 2-entry output FIFO occupancy plus in-flight reads < 2.
- mem_do[7:0] SHALL be pushed into the FIFO the cycle after issue.
REQ-012 The FIFO head SHALL drive out_data / out_valid; a pop SHALL occur on out_valid & out_ready.
REQ-013 Push and pop in the same cycle SHALL be allowed. With out_ready held high, dump throughput SHALL be 1 byte/cycle.
REQ-014 out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-015 After the L-th read is issued, the FSM SHALL enter DRAIN and leave it for DONE when the FIFO is empty and no read is in flight.
REQ-016 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-017 Bytes SHALL be emitted in index order starting at base.

Reset
REQ-018 On sys_rst = 1, including mid-transfer, the block SHALL:
- enter IDLE;
- clear counters, the FIFO and in-flight state;
- drive busy, done, in_ready, out_valid = 0, mem_we = 0, mem_addr = 0, mem_di = 0 and out_data = 0 from the next edge.
No partial transfer SHALL resume after reset.

Structure
REQ-019 State encodings, DEPTH and IDX_W SHALL live in shared package checker_pkg.
REQ-020 The 2-entry output FIFO SHALL be sub-module checker_byte_fifo2 (push, pop, data, full, empty, count).

Verification
REQ-021 Load: base = 0x010, len = 4, bytes A1 A2 A3 A4 continuous -> four writes, mem_we = 0001, mem_addr = 0x0080, 0x0088, 0x0090, 0x0098; done pulse the cycle after the 4th beat.
REQ-022 Wrap: load base = 0x7FE, len = 3 -> writes to indices 0x7FE, 0x7FF, 0x000 (mem_addr 0x3FF0, 0x3FF8, 0x0000).
REQ-023 Dump backpressure: memory preloaded 0x00..0x0F, base = 0, len = 16, out_ready toggled 1/0 -> out stream 00..0F in order with no loss or duplication, never more than 2 buffered; with out_ready = 1 constant, 16 consecutive valid cycles.
REQ-024 len = 0 -> done one cycle later with no mem_we / read activity; len = 3000 -> exactly 2048 beats.
REQ-025 sys_rst asserted after 5 of 10 load beats -> next cycle busy = 0, in_ready = 0, mem_we = 0; a new start then behaves normally.
REQ-026 start pulsed during DUMP -> ignored; the transfer completes unchanged.
